// File: rtl/data_mem_write_buffer_pkg.sv
// Shared widths and FSM encoding for the data-memory posted-write buffer.
// Imported by the buffer top level and its FIFO/CAM.
package data_mem_write_buffer_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_RDONE = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_write_buffer_wb_fifo_cam.sv
// Posted-write FIFO with a parallel address CAM.
// Returns youngest hit for reads and a merge target that skips the locked head.
module wb_fifo_cam
    import data_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq,
    input  logic              merge,
    input  logic              pop,
    input  logic              lock,
    input  logic [ADDR_W-1:0] look_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    output logic              merge_hit,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W:0]    count,
    output logic              full
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  hit_idx;
    logic [PTR_W-1:0]  merge_idx;
    logic [PTR_W-1:0]  idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        hit       = 1'b0;
        merge_hit = 1'b0;
        hit_idx   = head;
        merge_idx = head;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && addr_q[idx] == look_addr) begin
                hit     = 1'b1;
                hit_idx = idx;
                if (!(lock && i == 0)) begin
                    merge_hit = 1'b1;
                    merge_idx = idx;
                end
            end
        end
    end

    assign hit_data  = data_q[hit_idx];
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign full      = (count == (PTR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= look_addr;
            data_q[tail] <= wr_data;
        end else if (merge) begin
            data_q[merge_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, enq}
                           - {{PTR_W{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/data_mem_write_buffer.sv
// Posted-write buffer between the data cache memory port and data memory.
// Writes post in one cycle and drain in the background; read misses go first.
module data_mem_write_buffer
    import data_mem_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              C_READ,
    input  logic              C_WRITE,
    input  logic [ADDR_W-1:0] C_ADDRESS,
    input  logic [DATA_W-1:0] C_WRITE_DATA,
    output logic [DATA_W-1:0] C_READ_DATA,
    output logic              C_BUSY_WAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITE_DATA,
    input  logic [DATA_W-1:0] M_READ_DATA,
    input  logic              M_BUSY_WAIT,
    output logic              WB_EMPTY
);

    localparam int PTR_W = $clog2(DEPTH);

    state_t              state;
    state_t              state_next;
    logic                hit;
    logic [DATA_W-1:0]   hit_data;
    logic                merge_hit;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [PTR_W:0]      count;
    logic                full;
    logic                enq;
    logic                merge;
    logic                pop;
    logic                done;
    logic                read_miss;
    logic [DATA_W-1:0]   rd_q;

    wb_fifo_cam #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cam (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .enq      (enq),
        .merge    (merge),
        .pop      (pop),
        .lock     (state == ST_DRAIN),
        .look_addr(C_ADDRESS),
        .wr_data  (C_WRITE_DATA),
        .hit      (hit),
        .hit_data (hit_data),
        .merge_hit(merge_hit),
        .head_addr(head_addr),
        .head_data(head_data),
        .count    (count),
        .full     (full)
    );

    assign done      = (M_READ || M_WRITE) && !M_BUSY_WAIT;
    assign pop       = (state == ST_DRAIN) && M_WRITE && !M_BUSY_WAIT;
    assign read_miss = C_READ && !C_WRITE && !hit;
    assign WB_EMPTY  = (count == '0) && (state != ST_DRAIN);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (read_miss)          state_next = ST_READ;
                else if (count != '0)   state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!M_WRITE && read_miss) begin
                    state_next = ST_READ;
                end else if (pop) begin
                    if (read_miss)
                        state_next = ST_READ;
                    else if (count != {{PTR_W{1'b0}}, 1'b1} || enq)
                        state_next = ST_DRAIN;
                    else
                        state_next = ST_IDLE;
                end
            end
            ST_READ:  if (M_READ && done) state_next = ST_RDONE;
            ST_RDONE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        enq         = 1'b0;
        merge       = 1'b0;
        C_BUSY_WAIT = 1'b0;
        C_READ_DATA = '0;
        if (C_WRITE) begin
            merge       = merge_hit;
            enq         = !merge_hit && (!full || pop);
            C_BUSY_WAIT = !(merge_hit || !full || pop);
        end else if (C_READ) begin
            if (state == ST_RDONE) C_READ_DATA = rd_q;
            else if (hit)          C_READ_DATA = hit_data;
            else                   C_BUSY_WAIT = 1'b1;
        end
    end

    // Requests drop on the completion edge and re-issue a cycle later.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            M_READ       <= 1'b0;
            M_WRITE      <= 1'b0;
            M_ADDRESS    <= '0;
            M_WRITE_DATA <= '0;
            rd_q         <= '0;
        end else begin
            assert (!(C_READ && C_WRITE))
                else $error("write buffer: C_READ and C_WRITE both high");
            case (state)
                ST_DRAIN: begin
                    if (M_WRITE) begin
                        if (done) M_WRITE <= 1'b0;
                    end else if (state_next == ST_DRAIN) begin
                        M_WRITE      <= 1'b1;
                        M_ADDRESS    <= head_addr;
                        M_WRITE_DATA <= head_data;
                    end
                end
                ST_READ: begin
                    if (M_READ) begin
                        if (done) begin
                            M_READ <= 1'b0;
                            rd_q   <= M_READ_DATA;
                        end
                    end else begin
                        M_READ    <= 1'b1;
                        M_ADDRESS <= C_ADDRESS;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_write_buffer.sv
// Bench for the posted-write buffer: 5-cycle-busy memory model, cache driven directly.
// Expected reads and memory writes are queued and checked by a negedge monitor.
module tb_data_mem_write_buffer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        C_READ;
    logic        C_WRITE;
    logic [5:0]  C_ADDRESS;
    logic [31:0] C_WRITE_DATA;
    logic [31:0] C_READ_DATA;
    logic        C_BUSY_WAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [5:0]  M_ADDRESS;
    logic [31:0] M_WRITE_DATA;
    logic [31:0] M_READ_DATA;
    logic        M_BUSY_WAIT;
    logic        WB_EMPTY;

    int vectors = 0;
    int miscompares = 0;

    logic [37:0] exp_mw [$];
    logic [31:0] exp_rd [$];

    logic [31:0] mem [64];
    bit   [63:0] written;
    int          cnt;
    int          mem_writes;

    always #5 CLK = ~CLK;

    data_mem_write_buffer dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .C_READ      (C_READ),
        .C_WRITE     (C_WRITE),
        .C_ADDRESS   (C_ADDRESS),
        .C_WRITE_DATA(C_WRITE_DATA),
        .C_READ_DATA (C_READ_DATA),
        .C_BUSY_WAIT (C_BUSY_WAIT),
        .M_READ      (M_READ),
        .M_WRITE     (M_WRITE),
        .M_ADDRESS   (M_ADDRESS),
        .M_WRITE_DATA(M_WRITE_DATA),
        .M_READ_DATA (M_READ_DATA),
        .M_BUSY_WAIT (M_BUSY_WAIT),
        .WB_EMPTY    (WB_EMPTY)
    );

    function automatic logic [31:0] memval(input logic [5:0] a);
        return 32'hA500_0000 | {26'd0, a};
    endfunction

    // Memory model: busy for 5 cycles after a request rises.
    assign M_BUSY_WAIT = (M_READ || M_WRITE) && (cnt < 5);
    assign M_READ_DATA = written[M_ADDRESS] ? mem[M_ADDRESS]
                                            : memval(M_ADDRESS);

    always @(posedge CLK) begin
        if (!(M_READ || M_WRITE)) cnt <= 0;
        else if (cnt < 5)        cnt <= cnt + 1;
        if (M_WRITE && !M_BUSY_WAIT) begin
            mem[M_ADDRESS]     <= M_WRITE_DATA;
            written[M_ADDRESS] <= 1'b1;
            mem_writes         <= mem_writes + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET_N && M_WRITE && !M_BUSY_WAIT) begin
            if (exp_mw.size() == 0)
                chk("mem_write_unexpected", 64'(exp_mw.size()), 1);
            else
                chk("mem_write", {M_ADDRESS, M_WRITE_DATA},
                    exp_mw.pop_front());
        end
        if (RESET_N && C_READ && !C_BUSY_WAIT) begin
            if (exp_rd.size() == 0)
                chk("read_unexpected", 64'(exp_rd.size()), 1);
            else
                chk("read_data", C_READ_DATA, exp_rd.pop_front());
        end
    end

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            output int lat, output bit pop_seen);
        bit ok = 0;
        C_WRITE = 1'b1; C_ADDRESS = a; C_WRITE_DATA = d;
        lat = 0; pop_seen = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge CLK);
            lat++;
            if (!C_BUSY_WAIT) begin
                ok = 1;
                pop_seen = M_WRITE && !M_BUSY_WAIT;
            end else begin
                @(posedge CLK);
            end
        end
        if (!ok) chk("write_timeout", 64'(ok), 1);
        @(posedge CLK); #1;
        C_WRITE = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] expd,
                           output int lat, output bit saw_mr,
                           output int wr_at_mr);
        bit ok = 0;
        exp_rd.push_back(expd);
        C_READ = 1'b1; C_ADDRESS = a;
        lat = 0; saw_mr = 0; wr_at_mr = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge CLK);
            lat++;
            if (M_READ && !saw_mr) begin
                saw_mr = 1;
                wr_at_mr = mem_writes;
            end
            if (!C_BUSY_WAIT) ok = 1;
            else              @(posedge CLK);
        end
        if (!ok) chk("read_timeout", 64'(ok), 1);
        @(posedge CLK); #1;
        C_READ = 1'b0;
    endtask

    task automatic wait_mwrite();
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge CLK);
            if (M_WRITE) ok = 1;
        end
        if (!ok) chk("mwrite_timeout", 64'(ok), 1);
    endtask

    task automatic wait_empty();
        bit ok = 0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge CLK);
            if (WB_EMPTY && !M_WRITE) ok = 1;
        end
        if (!ok) chk("empty_timeout", 64'(ok), 1);
        @(posedge CLK); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wa;
        int base;
        bit ps;
        bit saw;
        RESET_N = 1'b0; C_READ = 1'b0; C_WRITE = 1'b0;
        C_ADDRESS = '0; C_WRITE_DATA = '0;
        repeat (2) @(negedge CLK);
        chk("rst_m_read", M_READ, 0);
        chk("rst_m_write", M_WRITE, 0);
        chk("rst_m_addr", M_ADDRESS, 0);
        chk("rst_m_wdata", M_WRITE_DATA, 0);
        chk("rst_busy", C_BUSY_WAIT, 0);
        chk("rst_wb_empty", WB_EMPTY, 1);
        @(posedge CLK); #1 RESET_N = 1'b1;

        // 1: reset during an in-flight drain drops it
        do_write(6'h05, 32'hAABBCCDD, lat, ps);
        chk("t1_wr_lat", lat, 1);
        wait_mwrite();
        chk("t1_m_addr", M_ADDRESS, 6'h05);
        @(negedge CLK); #2 RESET_N = 1'b0;
        #1;
        chk("t1_m_write_dropped", M_WRITE, 0);
        chk("t1_wb_empty", WB_EMPTY, 1);
        @(posedge CLK); #1 RESET_N = 1'b1;
        do_read(6'h05, memval(6'h05), lat, saw, wa);
        chk("t1_rd_to_mem", saw, 1);

        // 2: posted write then read hit
        exp_mw.push_back({6'h05, 32'h11223344});
        do_write(6'h05, 32'h11223344, lat, ps);
        chk("t2_wr_lat", lat, 1);
        do_read(6'h05, 32'h11223344, lat, saw, wa);
        chk("t2_rd_lat", lat, 1);
        chk("t2_no_mread", saw, 0);
        wait_empty();

        // 3: merge behind an in-flight drain
        exp_mw.push_back({6'h01, 32'hCAFE0001});
        exp_mw.push_back({6'h02, 32'h00000002});
        do_write(6'h01, 32'hCAFE0001, lat, ps);
        wait_mwrite();
        do_write(6'h02, 32'h00000001, lat, ps);
        chk("t3_wr1_lat", lat, 1);
        do_write(6'h02, 32'h00000002, lat, ps);
        chk("t3_merge_lat", lat, 1);
        wait_empty();
        do_read(6'h02, 32'h00000002, lat, saw, wa);
        chk("t3_rd_to_mem", saw, 1);

        // 4: fifth write stalls until the first pop
        for (int i = 0; i < 5; i++)
            exp_mw.push_back({6'(6'h10 + i), 32'(32'hF0 + i)});
        for (int i = 0; i < 4; i++) begin
            do_write(6'(6'h10 + i), 32'(32'hF0 + i), lat, ps);
            chk("t4_wr_lat", lat, 1);
        end
        do_write(6'h14, 32'hF4, lat, ps);
        chk("t4_full_stalled", lat > 1, 1);
        chk("t4_accept_on_pop", ps, 1);
        wait_empty();

        // 5: read miss overtakes queued writes
        for (int i = 0; i < 3; i++)
            exp_mw.push_back({6'(6'h20 + i), 32'(32'h2000 + i)});
        for (int i = 0; i < 3; i++)
            do_write(6'(6'h20 + i), 32'(32'h2000 + i), lat, ps);
        wait_mwrite();
        base = mem_writes;
        do_read(6'h3F, memval(6'h3F), lat, saw, wa);
        chk("t5_mread_seen", saw, 1);
        chk("t5_one_drain_first", wa, base + 1);
        chk("t5_writes_pending", WB_EMPTY, 0);
        wait_empty();

        // 6: same address twice, memory ends with the younger data
        exp_mw.push_back({6'h07, 32'h77770001});
        exp_mw.push_back({6'h07, 32'h77770002});
        do_write(6'h07, 32'h77770001, lat, ps);
        wait_empty();
        do_write(6'h07, 32'h77770002, lat, ps);
        wait_empty();
        do_read(6'h07, 32'h77770002, lat, saw, wa);
        chk("t6_rd_to_mem", saw, 1);

        repeat (3) @(negedge CLK);
        chk("pending_mem_writes", 64'(exp_mw.size()), 0);
        chk("pending_reads", 64'(exp_rd.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
